// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, muldiv sequencer states and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One sequencer iteration on magnitudes: shift-add multiply step or restoring-divide step.
// The divide step exists only with ALU_MULDIV_DIV_EN; otherwise a divide-mode step holds the accumulator.
module alu_muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_mode,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [2*WIDTH-1:0]   w_div_nxt;

  // acc = {partial product, remaining multiplier bits}; the carry lands in the top bit.
  assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                     (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_sum, i_acc[WIDTH-1:1]};

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Shifted remainder needs one extra bit before the trial subtract.
  assign w_rem_sh  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, i_opnd};
  assign w_div_nxt = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],   i_acc[WIDTH-2:0], 1'b1};
`else
  assign w_div_nxt = i_acc;
`endif

  assign o_acc = i_mode ? w_div_nxt : w_mul_nxt;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer: done WIDTH+2 edges after acceptance (divide-by-zero: 2); start ignored unless idle.
// Divider built only with ALU_MULDIV_DIV_EN; without it DIV/DIVU finish in 2 edges with HI/LO untouched.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

`ifdef ALU_MULDIV_DIV_EN
  localparam bit DIV_BUILT = 1'b1;
`else
  localparam bit DIV_BUILT = 1'b0;
`endif

  state_e             r_state;
  state_e             w_state_nxt;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_acc_init;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_res;
  logic               r_div_zero;
  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_skip_run;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_is_div   = op[1];
  assign w_signed   = op_is_signed(op_e'(op));
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  // Divides skip RUN when the divisor is zero, or always when no divider exists.
  assign w_skip_run = w_is_div & (~DIV_BUILT | (b == '0));
  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;

`ifdef ALU_MULDIV_DIV_EN
  logic             r_neg_rem;
  logic             r_dz_pend;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Divide-by-zero returns the raw dividend in HI, so keep it unmodified.
  assign w_acc_init = (w_is_div && (b == '0)) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, w_a_mag};
  assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
  assign w_acc_init = {{WIDTH{1'b0}}, w_a_mag};
`endif

  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_mode (r_op[1]),
    .o_acc  (w_acc_step)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = w_skip_run ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_op       <= OP_MUL;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_neg_res  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      r_neg_rem  <= 1'b0;
      r_dz_pend  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op       <= op_e'(op);
            r_cnt      <= '0;
            r_acc      <= w_acc_init;
            r_opnd     <= w_b_mag;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_div_zero <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            r_neg_rem  <= w_a_neg;
            r_dz_pend  <= w_is_div && (b == '0);
`endif
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!r_op[1]) begin
            {r_hi, r_lo} <= w_prod_fix;
          end
`ifdef ALU_MULDIV_DIV_EN
          else if (r_dz_pend) begin
            r_hi       <= r_acc[WIDTH-1:0];
            r_lo       <= '1;
            r_div_zero <= 1'b1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed vectors, arithmetic reference model, per-cycle output compare.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: currently visible HI/LO/div_zero and the pending result.
  bit           m_active  = 1'b0;
  int           m_elapsed = 0;
  int           m_lat     = 0;
  logic [W-1:0] m_hi      = '0;
  logic [W-1:0] m_lo      = '0;
  logic         m_dz      = 1'b0;
  logic [W-1:0] m_nhi     = '0;
  logic [W-1:0] m_nlo     = '0;
  logic         m_ndz     = 1'b0;

  alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_accept(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    longint          sp;
    longint unsigned up;
    int              sq;
    int              sr;
    m_active  = 1'b1;
    m_elapsed = 0;
    m_dz      = 1'b0;
    m_ndz     = 1'b0;
    m_lat     = W + 2;
    m_nhi     = m_hi;
    m_nlo     = m_lo;
    case (o)
      OP_MUL: begin
        sp = longint'($signed(va)) * longint'($signed(vb));
        {m_nhi, m_nlo} = sp;
      end
      OP_MULU: begin
        up = {32'b0, va} * {32'b0, vb};
        {m_nhi, m_nlo} = up;
      end
      default: begin
`ifdef ALU_MULDIV_DIV_EN
        if (vb == 0) begin
          m_nhi = va; m_nlo = '1; m_ndz = 1'b1; m_lat = 2;
        end else if (o == OP_DIV && va == 32'h80000000 && vb == 32'hFFFFFFFF) begin
          m_nhi = '0; m_nlo = 32'h80000000;
        end else if (o == OP_DIV) begin
          sq = $signed(va) / $signed(vb);
          sr = $signed(va) % $signed(vb);
          m_nhi = sr; m_nlo = sq;
        end else begin
          m_nlo = va / vb; m_nhi = va % vb;
        end
`else
        m_lat = 2;
`endif
      end
    endcase
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_hi     = '0;
    m_lo     = '0;
    m_dz     = 1'b0;
  endtask

  // Latency counts the acceptance edge as edge 1.
  always @(negedge clock) begin
    if (m_active) begin
      m_elapsed++;
      chk("busy_active", busy, 1'b1);
      chk("done_timing", done, (m_elapsed == m_lat));
      if (m_elapsed == m_lat) begin
        m_hi = m_nhi; m_lo = m_nlo; m_dz = m_ndz; m_active = 1'b0;
      end
    end else begin
      chk("busy_idle", busy, 1'b0);
      chk("done_idle", done, 1'b0);
    end
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div_zero", div_zero, m_dz);
  end

  // mode: 0 plain, 1 second start mid-RUN, 2 start during DONE, 3 reset at iteration 10
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input int mode, input logic [W-1:0] lh, input logic [W-1:0] ll,
                        input logic ld, input int llat);
    bit seen;
    int lat;
    @(negedge clock);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clock);
    model_accept(o, va, vb);
    #1 start = 1'b0;
    if (mode == 3) begin
      repeat (10) @(posedge clock);
      #2 clear_n = 1'b0;
      model_reset();
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clock);
      @(posedge clock);
      #2 clear_n = 1'b1;
      return;
    end
    if (mode == 1) begin
      repeat (5) @(negedge clock);
      op = OP_MULU; a = 32'd3; b = 32'd3; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (mode == 1) lat = i + 7;
      else lat = i + 1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      chk("lit_latency", lat, llat);
      chk("lit_hi", hi, lh);
      chk("lit_lo", lo, ll);
      chk("lit_dz", div_zero, ld);
    end
    if (mode == 2) begin
      op = OP_MUL; a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    clear_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_dz", div_zero, 1'b0);
    clear_n = 1'b1;

    run_op(OP_MUL,  32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run_op(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
`ifdef ALU_MULDIV_DIV_EN
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run_op(OP_DIVU, 32'd100,      32'd7,        0, 32'd2,        32'd14,       1'b0, 34);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 0, 32'h0,        32'h80000000, 1'b0, 34);
    run_op(OP_DIVU, 32'd5,        32'd0,        0, 32'd5,        32'hFFFFFFFF, 1'b1, 2);
`else
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2);
    run_op(OP_DIVU, 32'd100,      32'd7,        0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2);
    run_op(OP_DIVU, 32'd5,        32'd0,        0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2);
`endif
    run_op(OP_MUL,  32'h00012345, 32'h00000100, 1, 32'h0,        32'h01234500, 1'b0, 34);
    run_op(OP_MULU, 32'd6,        32'd7,        2, 32'h0,        32'd42,       1'b0, 34);
    run_op(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'h0,        32'h0,        1'b0, 0);
    run_op(OP_MUL,  32'hFFFFFFFB, 32'd6,        0, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 34);
    run_op(OP_MUL,  32'h80000000, 32'h80000000, 0, 32'h40000000, 32'h0,        1'b0, 34);
`ifdef ALU_MULDIV_DIV_EN
    run_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 0, 32'd1,        32'hFFFFFFFD, 1'b0, 34);
`else
    run_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 0, 32'h40000000, 32'h0,        1'b0, 2);
`endif

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
